// File: rtl/reg_alu_sequencer_if.sv
// Instruction handshake plus register-file/ALU control bundle for reg_alu_sequencer.
interface reg_alu_sequencer_if #(
   parameter int REP_W = 4,
   parameter int CNT_W = 16
);
   logic             instr_valid;
   logic             instr_ready;
   logic [15:0]      instr;
   logic [7:0]       imm_in;
   logic [REP_W-1:0] rep_in;
   logic             abort;
   logic [7:0]       ALUResult;
   logic [3:0]       RA1;
   logic [3:0]       RA2;
   logic [3:0]       WA;
   logic [7:0]       external_data_in;
   logic             RegWrite;
   logic             ALUSrc;
   logic [1:0]       ALUControl;
   logic             busy;
   logic             done;
   logic [7:0]       result_out;
   logic [CNT_W-1:0] op_count;

   modport slave (
      input  instr_valid, instr, imm_in, rep_in, abort, ALUResult,
      output instr_ready, RA1, RA2, WA, external_data_in, RegWrite, ALUSrc,
             ALUControl, busy, done, result_out, op_count
   );

   modport master (
      output instr_valid, instr, imm_in, rep_in, abort, ALUResult,
      input  instr_ready, RA1, RA2, WA, external_data_in, RegWrite, ALUSrc,
             ALUControl, busy, done, result_out, op_count
   );
endinterface

// File: rtl/reg_alu_sequencer.sv
// Multi-cycle sequencer driving the register-file/ALU datapath with an accumulate-repeat loop.
// Optional completed-op counter enabled by defining SEQ_PERF_EN.
module reg_alu_sequencer #(
   parameter int REP_W = 4,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                reset,
   reg_alu_sequencer_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t           state_q, state_d;
   logic [REP_W-1:0] iter_q, iter_d;
   logic [REP_W-1:0] rep_q, rep_d;
   logic [3:0]       ra1_q, ra1_d;
   logic [3:0]       ra2_q, ra2_d;
   logic [3:0]       wa_q, wa_d;
   logic [7:0]       imm_q, imm_d;
   logic             alusrc_q, alusrc_d;
   logic [1:0]       aluctl_q, aluctl_d;
   logic [7:0]       result_q, result_d;
   logic             accept;
   logic             done_entry;
   logic             unused_reserved;

   assign unused_reserved = bus.instr[0];
   assign accept          = bus.instr_valid && bus.instr_ready;
   // Abort takes priority over completion so an aborted final iteration never reports done.
   assign done_entry      = (state_q == EXEC) && !bus.abort && (iter_q == rep_q);

   always_comb begin
      state_d  = state_q;
      iter_d   = iter_q;
      rep_d    = rep_q;
      ra1_d    = ra1_q;
      ra2_d    = ra2_q;
      wa_d     = wa_q;
      imm_d    = imm_q;
      alusrc_d = alusrc_q;
      aluctl_d = aluctl_q;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = EXEC;
               iter_d   = '0;
               rep_d    = bus.rep_in;
               alusrc_d = bus.instr[15];
               aluctl_d = bus.instr[14:13];
               wa_d     = bus.instr[12:9];
               ra1_d    = bus.instr[8:5];
               ra2_d    = bus.instr[4:1];
               imm_d    = bus.imm_in;
            end
         end
         EXEC: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (done_entry) begin
               state_d  = DONE;
               result_d = bus.ALUResult;
            end else begin
               // Later iterations accumulate into rd.
               iter_d = iter_q + 1'b1;
               ra1_d  = wa_q;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         iter_q   <= '0;
         rep_q    <= '0;
         ra1_q    <= '0;
         ra2_q    <= '0;
         wa_q     <= '0;
         imm_q    <= '0;
         alusrc_q <= 1'b0;
         aluctl_q <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         iter_q   <= iter_d;
         rep_q    <= rep_d;
         ra1_q    <= ra1_d;
         ra2_q    <= ra2_d;
         wa_q     <= wa_d;
         imm_q    <= imm_d;
         alusrc_q <= alusrc_d;
         aluctl_q <= aluctl_d;
         result_q <= result_d;
      end
   end

   assign bus.instr_ready      = (state_q == IDLE) && !reset;
   assign bus.busy             = (state_q == EXEC);
   assign bus.done             = (state_q == DONE);
   assign bus.RegWrite         = (state_q == EXEC) && !bus.abort;
   assign bus.RA1              = ra1_q;
   assign bus.RA2              = ra2_q;
   assign bus.WA               = wa_q;
   assign bus.external_data_in = imm_q;
   assign bus.ALUSrc           = alusrc_q;
   assign bus.ALUControl       = aluctl_q;
   assign bus.result_out       = result_q;

`ifdef SEQ_PERF_EN
   logic [CNT_W-1:0] op_count_q, op_count_d;

   always_comb begin
      op_count_d = op_count_q;
      if (done_entry) op_count_d = op_count_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) op_count_q <= '0;
      else       op_count_q <= op_count_d;
   end

   assign bus.op_count = op_count_q;
`else
   assign bus.op_count = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_reg_alu_sequencer.sv
// Self-checking bench for reg_alu_sequencer: directed plus random ops against an instruction-level model.
module tb_reg_alu_sequencer;
   localparam int REP_W = 4;
   localparam int CNT_W = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   reg_alu_sequencer_if #(.REP_W(REP_W), .CNT_W(CNT_W)) bus ();
   reg_alu_sequencer #(.REP_W(REP_W), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int passed = 0;
   int total  = 0;
   int failed = 0;

   logic [7:0]       seed_v;
   logic [7:0]       rf  [16];
   logic [7:0]       mrf [16];
   logic [7:0]       exp_res;
   logic [CNT_W-1:0] exp_ops;

   function automatic logic [7:0] alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         2'd0:    return a + b;
         2'd1:    return a - b;
         2'd2:    return a & b;
         default: return a ^ b;
      endcase
   endfunction

   function automatic logic [7:0] init_val(input int i);
      return 8'(i * 37) ^ seed_v;
   endfunction

   function automatic logic [CNT_W-1:0] exp_count();
`ifdef SEQ_PERF_EN
      return exp_ops;
`else
      return '0;
`endif
   endfunction

   // Register file and ALU the sequencer drives: combinational read, write at the edge.
   assign bus.ALUResult = alu(bus.ALUControl, rf[bus.RA1], bus.ALUSrc ? bus.external_data_in : rf[bus.RA2]);
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 16; i++) rf[i] <= init_val(i);
      end else if (bus.RegWrite) begin
         rf[bus.WA] <= bus.ALUResult;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) mrf[i] = init_val(i);
      exp_res = '0;
      exp_ops = '0;
   endtask

   task automatic check_regfile(input string tag);
      int bad;
      bad = 0;
      for (int i = 0; i < 16; i++) if (rf[i] !== mrf[i]) bad++;
      check(tag, bad, 0);
   endtask

   // One instruction: rep+1 iterations, optionally aborted at EXEC cycle abort_at.
   task automatic run_op(input logic [15:0] ins, input logic [7:0] imm, input logic [REP_W-1:0] rep,
                         input int abort_at, input bit hold_next, input logic [15:0] nins,
                         input logic [7:0] nimm, input logic [REP_W-1:0] nrep);
      logic [3:0] rd, rs1, rs2;
      logic       sel;
      logic [1:0] op;
      logic [7:0] last;
      bit         aborted;
      int         n_it;
      rd  = ins[12:9];
      rs1 = ins[8:5];
      rs2 = ins[4:1];
      sel = ins[15];
      op  = ins[14:13];
      last = '0;
      aborted = 1'b0;
      n_it = int'(rep) + 1;
      bus.instr = ins; bus.imm_in = imm; bus.rep_in = rep; bus.instr_valid = 1'b1;
      #1;
      check("ready_idle", bus.instr_ready, 1);
      @(posedge clk); #1;
      if (hold_next) begin
         bus.instr = nins; bus.imm_in = nimm; bus.rep_in = nrep;
      end else begin
         bus.instr_valid = 1'b0;
      end
      for (int k = 0; k < n_it; k++) begin
         bus.abort = (k == abort_at);
         #1;
         check("busy", bus.busy, 1);
         check("ready_exec", bus.instr_ready, 0);
         check("regwrite", bus.RegWrite, (k != abort_at));
         check("ra1", bus.RA1, (k == 0) ? rs1 : rd);
         check("ra2", bus.RA2, rs2);
         check("wa", bus.WA, rd);
         check("alusrc", bus.ALUSrc, sel);
         check("aluctl", bus.ALUControl, op);
         check("imm", bus.external_data_in, imm);
         if (k == abort_at) begin
            aborted = 1'b1;
            @(posedge clk); #1;
            bus.abort = 1'b0;
            break;
         end
         mrf[rd] = alu(op, mrf[(k == 0) ? rs1 : rd], sel ? imm : mrf[rs2]);
         last = mrf[rd];
         @(posedge clk); #1;
      end
      if (aborted) begin
         check("abort_idle", bus.instr_ready, 1);
         check("abort_nodone", bus.done, 0);
         check("abort_busy", bus.busy, 0);
      end else begin
         check("done", bus.done, 1);
         check("done_busy", bus.busy, 0);
         check("done_regwrite", bus.RegWrite, 0);
         check("ready_done", bus.instr_ready, 0);
         exp_res = last;
         exp_ops = exp_ops + 1'b1;
         @(posedge clk); #1;
         check("done_pulse", bus.done, 0);
         check("ready_after", bus.instr_ready, 1);
      end
      check("result", bus.result_out, exp_res);
      check("op_count", bus.op_count, exp_count());
      check_regfile("regfile");
   endtask

   initial begin
      logic [15:0] ins, ins_b;
      logic [7:0]  imm;
      logic [REP_W-1:0] rep;
      seed_v = 8'($urandom);
      reset = 1'b1;
      bus.instr_valid = 1'b0; bus.instr = '0; bus.imm_in = '0; bus.rep_in = '0; bus.abort = 1'b0;
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      check("rst_ready", bus.instr_ready, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_regwrite", bus.RegWrite, 0);
      check("rst_addr", {bus.RA1, bus.RA2, bus.WA}, 0);
      check("rst_ctl", {bus.ALUSrc, bus.ALUControl, bus.external_data_in}, 0);
      check("rst_result", bus.result_out, 0);
      check("rst_op_count", bus.op_count, 0);
      reset = 1'b0;
      #1;
      check("ready_out_of_reset", bus.instr_ready, 1);
      @(posedge clk); #1;

      // Abort outside EXEC does nothing.
      bus.abort = 1'b1;
      @(posedge clk); #1;
      check("idle_abort_ready", bus.instr_ready, 1);
      check("idle_abort_busy", bus.busy, 0);
      bus.abort = 1'b0;

      run_op({1'b1, 2'b01, 4'd3, 4'd2, 4'd5, 1'b0}, 8'h2A, 4'd0, -1, 1'b0, '0, '0, '0);
      run_op({1'b0, 2'b00, 4'd1, 4'd0, 4'd2, 1'b0}, 8'h00, 4'd3, -1, 1'b0, '0, '0, '0);
      // rd aliasing both sources, maximum repeat count.
      run_op({1'b0, 2'b00, 4'd7, 4'd7, 4'd7, 1'b0}, 8'h11, 4'd15, -1, 1'b0, '0, '0, '0);

      // Back-to-back: second instruction held valid throughout the first.
      ins   = {1'b1, 2'b00, 4'd4, 4'd6, 4'd1, 1'b0};
      ins_b = {1'b0, 2'b11, 4'd9, 4'd4, 4'd8, 1'b0};
      run_op(ins, 8'h05, 4'd1, -1, 1'b1, ins_b, 8'h77, 4'd2);
      run_op(ins_b, 8'h77, 4'd2, -1, 1'b0, '0, '0, '0);
      @(posedge clk); #1;
      check("no_duplicate", bus.busy, 0);

      run_op({1'b0, 2'b01, 4'd2, 4'd3, 4'd4, 1'b0}, 8'h00, 4'd7, 2, 1'b0, '0, '0, '0);

      for (int n = 0; n < 20; n++) begin
         ins = 16'($urandom);
         imm = 8'($urandom);
         rep = REP_W'($urandom_range(0, 15));
         run_op(ins, imm, rep, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1,
                1'b0, '0, '0, '0);
      end

      // Reset in the middle of EXEC iteration 1.
      bus.instr = {1'b0, 2'b00, 4'd5, 4'd6, 4'd7, 1'b0}; bus.imm_in = 8'h3C; bus.rep_in = 4'd5;
      bus.instr_valid = 1'b1;
      @(posedge clk); #1;
      bus.instr_valid = 1'b0;
      @(posedge clk); #1;
      check("midop_busy", bus.busy, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      model_reset();
      check("midop_rst_regwrite", bus.RegWrite, 0);
      check("midop_rst_busy", bus.busy, 0);
      check("midop_rst_done", bus.done, 0);
      check("midop_rst_ready", bus.instr_ready, 0);
      check("midop_rst_outs", {bus.RA1, bus.RA2, bus.WA, bus.ALUSrc, bus.ALUControl, bus.external_data_in}, 0);
      check("midop_rst_result", bus.result_out, 0);
      check("midop_rst_op_count", bus.op_count, 0);
      reset = 1'b0;
      #1;
      check("midop_ready", bus.instr_ready, 1);
      @(posedge clk); #1;
      check("midop_no_done", bus.done, 0);

      // Three completed ops and one aborted op after a fresh reset.
      run_op({1'b1, 2'b00, 4'd1, 4'd1, 4'd0, 1'b0}, 8'h01, 4'd2, -1, 1'b0, '0, '0, '0);
      run_op({1'b0, 2'b10, 4'd2, 4'd1, 4'd3, 1'b0}, 8'h00, 4'd0, -1, 1'b0, '0, '0, '0);
      run_op({1'b0, 2'b00, 4'd8, 4'd8, 4'd2, 1'b0}, 8'h00, 4'd4, 3, 1'b0, '0, '0, '0);
      run_op({1'b1, 2'b11, 4'd3, 4'd2, 4'd0, 1'b0}, 8'hF0, 4'd1, -1, 1'b0, '0, '0, '0);
      check("final_op_count", bus.op_count, exp_count());

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
